result_tx_serializer: RTL and testbench

- Downstream stage of the matrix-vector Processor.
- Captures the 160-bit result word (eight 20-bit results) when the Processor's OP_DONE pulses, then streams it byte-by-byte to the UART transmitter over a valid/ready handshake.
- Sends one frame per operation: header byte, MAT_SIZE results of 3 bytes each, tail byte.
- Decouples the Processor from serial-line timing; the Processor may start its next operation as soon as the capture is done.

---
 rtl/result_tx_serializer.sv | 167 ++++++++++++++++
 tb/tb_result_tx_serializer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/result_tx_serializer.sv
// Captures a packed result word on OP_DONE and streams it as a byte frame
// (header, 3 bytes per result, tail) over a valid/ready handshake.
// Optional build macro RESULT_TX_CHECKSUM_EN inserts an XOR checksum byte before the tail.
module result_tx_serializer #(
    parameter int          NUM_RES   = 8,
    parameter int          RES_W     = 20,
    parameter logic [7:0]  HDR_BYTE  = 8'hFE,
    parameter logic [7:0]  TAIL_BYTE = 8'hEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     OP_DONE,
    input  logic [3:0]               MAT_SIZE,
    input  logic [NUM_RES*RES_W-1:0] DATA_IN,
    input  logic                     TX_READY,
    output logic [7:0]               TX_DATA,
    output logic                     TX_VALID,
    output logic                     BUSY,
    output logic                     OVERRUN
);

    localparam int DW = NUM_RES * RES_W;
    localparam int CW = (NUM_RES > 1) ? $clog2(NUM_RES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_PAY,
`ifdef RESULT_TX_CHECKSUM_EN
        S_CHK,
`endif
        S_TAIL
    } state_t;

`ifdef RESULT_TX_CHECKSUM_EN
    localparam state_t S_POST = S_CHK;
`else
    localparam state_t S_POST = S_TAIL;
`endif

    state_t          state_q, state_d;
    logic [DW-1:0]   data_q, data_d;
    logic [3:0]      n_q, n_d;
    logic [CW-1:0]   r_q, r_d;
    logic [1:0]      b_q, b_d;
    logic            overrun_q, overrun_d;
`ifdef RESULT_TX_CHECKSUM_EN
    logic [7:0]      chk_q, chk_d;
`endif

    logic            xfer;
    logic            capture_ok;
    logic            capture;
    logic [3:0]      n_eff;
    logic [23:0]     res24;
    logic [7:0]      pay_byte;
    logic            last_res;

    assign TX_VALID   = (state_q != S_IDLE);
    assign BUSY       = TX_VALID;
    assign OVERRUN    = overrun_q;
    assign xfer       = TX_VALID & TX_READY;
    assign capture_ok = (state_q == S_IDLE) || ((state_q == S_TAIL) && xfer);
    assign capture    = OP_DONE & capture_ok;
    assign n_eff      = (MAT_SIZE > 4'(NUM_RES)) ? 4'(NUM_RES) : MAT_SIZE;
    assign last_res   = ((4'(r_q) + 4'd1) == n_q);

    // The current result always sits at the top of data_q; it is shifted out after its third byte.
    assign res24 = 24'(data_q[DW-1 -: RES_W]);

    always_comb begin
        case (b_q)
            2'd0:    pay_byte = res24[23:16];
            2'd1:    pay_byte = res24[15:8];
            default: pay_byte = res24[7:0];
        endcase
    end

    always_comb begin
        case (state_q)
            S_HDR:   TX_DATA = HDR_BYTE;
            S_PAY:   TX_DATA = pay_byte;
`ifdef RESULT_TX_CHECKSUM_EN
            S_CHK:   TX_DATA = chk_q;
`endif
            S_TAIL:  TX_DATA = TAIL_BYTE;
            default: TX_DATA = 8'h00;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        n_d       = n_q;
        r_d       = r_q;
        b_d       = b_q;
        overrun_d = overrun_q | (OP_DONE & ~capture_ok);
`ifdef RESULT_TX_CHECKSUM_EN
        chk_d     = chk_q;
`endif
        case (state_q)
            S_HDR: begin
                if (xfer) state_d = (n_q != 4'd0) ? S_PAY : S_POST;
            end
            S_PAY: begin
                if (xfer) begin
`ifdef RESULT_TX_CHECKSUM_EN
                    chk_d = chk_q ^ pay_byte;
`endif
                    if (b_q == 2'd2) begin
                        b_d    = 2'd0;
                        r_d    = r_q + CW'(1);
                        data_d = data_q << RES_W;
                        if (last_res) state_d = S_POST;
                    end else begin
                        b_d = b_q + 2'd1;
                    end
                end
            end
`ifdef RESULT_TX_CHECKSUM_EN
            S_CHK: begin
                if (xfer) state_d = S_TAIL;
            end
`endif
            S_TAIL: begin
                if (xfer) state_d = S_IDLE;
            end
            default: ;
        endcase
        // A capture in TAIL overrides the return to IDLE, giving back-to-back frames.
        if (capture) begin
            state_d = S_HDR;
            data_d  = DATA_IN;
            n_d     = n_eff;
            r_d     = '0;
            b_d     = 2'd0;
`ifdef RESULT_TX_CHECKSUM_EN
            chk_d   = 8'h00;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            data_q    <= '0;
            n_q       <= 4'd0;
            r_q       <= '0;
            b_q       <= 2'd0;
            overrun_q <= 1'b0;
`ifdef RESULT_TX_CHECKSUM_EN
            chk_q     <= 8'h00;
`endif
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            n_q       <= n_d;
            r_q       <= r_d;
            b_q       <= b_d;
            overrun_q <= overrun_d;
`ifdef RESULT_TX_CHECKSUM_EN
            chk_q     <= chk_d;
`endif
        end
    end

endmodule

// File: tb/tb_result_tx_serializer.sv
// Scoreboard bench for result_tx_serializer: frames are built from the byte-level
// frame rules into a queue; a negedge monitor pops and compares on every transfer.
module tb_result_tx_serializer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         OP_DONE = 1'b0;
    logic [3:0]   MAT_SIZE = 4'd0;
    logic [159:0] DATA_IN = '0;
    logic         TX_READY = 1'b1;
    logic [7:0]   TX_DATA;
    logic         TX_VALID;
    logic         BUSY;
    logic         OVERRUN;

    int checks = 0;
    int errors = 0;
    int rdy_mode = 0;
    int rdy_ph = 0;
    logic [7:0] exp_q[$];

`ifdef RESULT_TX_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    result_tx_serializer dut (
        .clk(clk), .rst(rst), .OP_DONE(OP_DONE), .MAT_SIZE(MAT_SIZE),
        .DATA_IN(DATA_IN), .TX_READY(TX_READY), .TX_DATA(TX_DATA),
        .TX_VALID(TX_VALID), .BUSY(BUSY), .OVERRUN(OVERRUN)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [159:0] rand160();
        logic [159:0] r;
        for (int i = 0; i < 5; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Reference frame: header, 3 zero-padded bytes per result, optional XOR, tail.
    task automatic push_frame(input logic [3:0] mat, input logic [159:0] d);
        int n;
        logic [23:0] res;
        logic [7:0] x;
        x = 8'h00;
        n = (mat > 4'd8) ? 8 : int'(mat);
        exp_q.push_back(8'hFE);
        for (int k = 0; k < n; k++) begin
            res = {4'h0, d[159-20*k -: 20]};
            exp_q.push_back(res[23:16]);
            exp_q.push_back(res[15:8]);
            exp_q.push_back(res[7:0]);
            x = x ^ res[23:16] ^ res[15:8] ^ res[7:0];
        end
        if (CK == 1) exp_q.push_back(x);
        exp_q.push_back(8'hEF);
    endtask

    task automatic send_op(input logic [3:0] mat, input logic [159:0] d);
        @(posedge clk); #1;
        OP_DONE = 1'b1; MAT_SIZE = mat; DATA_IN = d;
        push_frame(mat, d);
        @(posedge clk); #1;
        OP_DONE = 1'b0; DATA_IN = rand160();
    endtask

    task automatic run_check(input int len);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            check("valid_run", 32'(TX_VALID), 32'd1);
        end
        @(negedge clk);
        check("busy_low_after_tail", 32'(BUSY), 32'd0);
    endtask

    task automatic wait_idle(input int budget);
        int c;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while ((exp_q.size() != 0 || BUSY) && c < budget);
        check("frame_complete_pending", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0: TX_READY = 1'b1;
                1: begin
                    TX_READY = ((rdy_ph % 4) == 0) || ((rdy_ph % 4) == 3);
                    rdy_ph++;
                end
                default: TX_READY = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: compares every transferred byte and checks stability during stalls.
    initial begin
        logic stall;
        logic [7:0] sd;
        logic [7:0] e;
        stall = 1'b0;
        sd = 8'h00;
        forever begin
            @(negedge clk);
            if (stall && !rst) begin
                check("stall_valid_held", 32'(TX_VALID), 32'd1);
                check("stall_data_stable", 32'(TX_DATA), 32'(sd));
            end
            stall = TX_VALID && !TX_READY;
            sd = TX_DATA;
            if (TX_VALID && TX_READY) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got %0h, expected no transfer at %0t", TX_DATA, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_byte", 32'(TX_DATA), 32'(e));
                end
            end
            check("busy_matches_valid", 32'(BUSY), 32'(TX_VALID));
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        logic [159:0] d;
        int found;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_valid", 32'(TX_VALID), 32'd0);
        check("reset_data", 32'(TX_DATA), 32'h00);
        check("reset_busy", 32'(BUSY), 32'd0);
        check("reset_overrun", 32'(OVERRUN), 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Single result, continuous ready.
        d = rand160();
        d[159:140] = 20'hABCDE;
        send_op(4'd1, d);
        run_check(5 + CK);

        // Full frame with 1,0,0,1 backpressure.
        rdy_mode = 1; rdy_ph = 0;
        d = '0;
        for (int k = 0; k < 8; k++) d[159-20*k -: 20] = 20'(k + 1);
        send_op(4'd8, d);
        wait_idle(200);

        // Boundary sizes.
        rdy_mode = 0;
        send_op(4'd0, rand160());
        run_check(2 + CK);
        send_op(4'hF, d);
        run_check(26 + CK);

        // Overrun: second OP_DONE while the first frame is in progress.
        rdy_mode = 2;
        send_op(4'd8, rand160());
        repeat (6) @(posedge clk);
        #1 OP_DONE = 1'b1; MAT_SIZE = 4'd3; DATA_IN = rand160();
        @(posedge clk); #1 OP_DONE = 1'b0;
        @(negedge clk);
        check("overrun_set", 32'(OVERRUN), 32'd1);
        wait_idle(400);
        for (int i = 0; i < 6; i++) begin
            send_op(4'($urandom_range(0, 15)), rand160());
            wait_idle(400);
        end
        check("overrun_sticky", 32'(OVERRUN), 32'd1);
        pulse_reset();
        @(negedge clk);
        check("overrun_cleared", 32'(OVERRUN), 32'd0);

        // Back-to-back: OP_DONE in the cycle the tail transfers.
        rdy_mode = 0;
        d = '0;
        d[159:140] = 20'h12345;
        d[139:120] = 20'h6789A;
        send_op(4'd2, d);
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            @(negedge clk);
            if (TX_VALID && TX_READY && TX_DATA == 8'hEF) found = 1;
        end
        check("b2b_tail_seen", 32'(found), 32'd1);
        d = rand160();
        OP_DONE = 1'b1; MAT_SIZE = 4'd1; DATA_IN = d;
        push_frame(4'd1, d);
        @(posedge clk); #1 OP_DONE = 1'b0;
        @(negedge clk);
        check("b2b_header", 32'(TX_DATA), 32'hFE);
        check("b2b_busy", 32'(BUSY), 32'd1);
        check("b2b_no_overrun", 32'(OVERRUN), 32'd0);
        wait_idle(100);

        // Reset during result 2.
        send_op(4'd8, rand160());
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("rst_mid_valid", 32'(TX_VALID), 32'd0);
        check("rst_mid_busy", 32'(BUSY), 32'd0);
        repeat (10) begin
            @(negedge clk);
            check("rst_mid_quiet", 32'(TX_VALID), 32'd0);
        end
        send_op(4'd2, rand160());
        wait_idle(100);

        // Randomized frames under random backpressure.
        rdy_mode = 2;
        for (int i = 0; i < 15; i++) begin
            send_op(4'($urandom_range(0, 15)), rand160());
            wait_idle(400);
        end
        check("final_no_overrun", 32'(OVERRUN), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
